// File: rtl/dmem_responder_pkg.sv
// Dmem_Resp_PKG: shared types and helpers for the data-memory responder.
// Holds the FSM state enum, RISC-V load/store funct3 codes, the latched
// request record, and helpers that classify access size and alignment.
// Sizes are decoded from funct3[1:0]: 00 byte, 01 half, anything else word,
// so 011/110/111 fall through to word accesses.
package Dmem_Resp_PKG;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int REQ_ADDR_W = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [2:0]            funct3;
    } req_t;

    function automatic logic is_byte(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return is_byte(f3) ? 1'b0 : is_half(f3) ? off[0] : (off != 2'b00);
    endfunction

    function automatic logic [1:0] align(input logic [2:0] f3, input logic [1:0] off);
        return is_byte(f3) ? off : is_half(f3) ? {off[1], 1'b0} : 2'b00;
    endfunction

endpackage

// File: rtl/dmem_responder_load_extract.sv
// load_extract: picks the byte/half lane of a word and sign/zero-extends it.
// Ports: word (storage word), off (byte offset addr[1:0]), funct3 (access
// size/sign), data (extended load result).
module load_extract
    import Dmem_Resp_PKG::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{off, 3'b000} +: 8];
    assign lane_h = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = funct3 == F3_LB  ? {{24{lane_b[7]}}, lane_b} :
               funct3 == F3_LBU ? {24'b0, lane_b} :
               funct3 == F3_LH  ? {{16{lane_h[15]}}, lane_h} :
               funct3 == F3_LHU ? {16'b0, lane_h} :
                                  word;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with internal storage.
// Ports: clk, reset (sync, active-high); req_valid/req_ready handshake with
// req_we, req_addr (byte address), req_wdata (right-aligned), req_funct3;
// resp_valid (one-cycle pulse), resp_rdata (extended load data), resp_err
// (misalignment); busy (high outside IDLE, used as pipeline stall).
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report
// resp_err and are suppressed; otherwise the low address bits are forced to
// the aligned value and resp_err stays 0.
module dmem_responder
    import Dmem_Resp_PKG::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
    localparam logic [2:0] LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t state, next;
    logic [2:0] cnt;
    req_t req_q, cur;
    logic [31:0] mem [DEPTH];
    logic accept, enter_resp, mis, commit;
    logic [1:0] off;
    logic [DM_ADDRESS-3:0] idx;
    logic [3:0] be;
    logic [31:0] wword, rword, ext;
    logic unused_addr;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;

    // In IDLE the live inputs are the request (needed when WAIT_CYCLES=0 and
    // the store commits on the accept edge itself); afterwards the latched copy.
    assign cur = (state == IDLE) ? {req_we, REQ_ADDR_W'(req_addr), 32'(req_wdata), req_funct3} : req_q;
    assign unused_addr = ^cur.addr[REQ_ADDR_W-1:DM_ADDRESS];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = misaligned(cur.funct3, cur.addr[1:0]);
    assign off = cur.addr[1:0];
`else
    assign mis = 1'b0;
    assign off = align(cur.funct3, cur.addr[1:0]);
`endif

    assign idx   = cur.addr[DM_ADDRESS-1:2];
    assign be    = is_byte(cur.funct3) ? (4'b0001 << off) :
                   is_half(cur.funct3) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wword = is_byte(cur.funct3) ? {4{cur.wdata[7:0]}} :
                   is_half(cur.funct3) ? {2{cur.wdata[15:0]}} : cur.wdata;
    assign rword = mem[idx];

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    next = (cnt == LAST) ? RESP : WAIT;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign enter_resp = (next == RESP) && (state != RESP);
    // A reset arriving on the commit edge abandons the store.
    assign commit = !reset && enter_resp && cur.we && !mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next;
            cnt   <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) req_q <= cur;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    load_extract u_extract (
        .word   (rword),
        .off    (off),
        .funct3 (cur.funct3),
        .data   (ext)
    );

    assign resp_valid = state == RESP;
    assign resp_rdata = (state == RESP && !cur.we && !mis) ? DATA_W'(ext) : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign resp_err = (state == RESP) && mis;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for dmem_responder.
// Drives a WAIT_CYCLES=1 instance from a vector table and a WAIT_CYCLES=0
// instance for back-to-back throughput; expectations honour DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 0, reset = 1;
    logic req_valid = 0, req_we = 0, req_ready, resp_valid, resp_err, busy;
    logic [8:0] req_addr = 0;
    logic [31:0] req_wdata = 0, resp_rdata;
    logic [2:0] req_funct3 = 0;
    logic req_valid_z = 0, req_we_z = 0, req_ready_z, resp_valid_z, resp_err_z, busy_z;
    logic [8:0] req_addr_z = 0;
    logic [31:0] req_wdata_z = 0, resp_rdata_z;
    logic [2:0] req_funct3_z = 0;

    int checks = 0, errors = 0, cyc = 0;
    exp_t sbq[$];
    vec_t tbl[26];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
        .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_funct3(req_funct3_z),
        .resp_valid(resp_valid_z), .resp_rdata(resp_rdata_z), .resp_err(resp_err_z), .busy(busy_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=resp_valid required=none");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", 32'(resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'd2);
                end
            end else begin
                chk("idle_rdata", resp_rdata, 32'h0);
                chk("idle_err", 32'(resp_err), 32'h0);
            end
            chk("busy_vs_ready", 32'(busy), 32'(!req_ready));
        end
    end

    task automatic send(input vec_t v);
        int k;
        @(negedge clk);
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
        for (k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        sbq.push_back('{v.rdata, v.err, cyc - 1});
        req_valid = 0;
        @(negedge clk); chk("ready_low1", 32'(req_ready), 32'h0);
        @(negedge clk); chk("ready_low2", 32'(req_ready), 32'h0);
        @(negedge clk); chk("ready_back", 32'(req_ready), 32'h1);
        chk("drained", 32'(sbq.size()), 32'h0);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, nresp, c0;
        logic stop;
        tbl[0]  = '{1'b1, 9'h020, 32'h11223344, 3'b010, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 9'h021, 32'hABCDEF80, 3'b000, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 9'h021, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0};
        tbl[3]  = '{1'b0, 9'h021, 32'h0, 3'b100, 32'h00000080, 1'b0};
        tbl[4]  = '{1'b0, 9'h020, 32'h0, 3'b001, 32'hFFFF8044, 1'b0};
        tbl[5]  = '{1'b0, 9'h022, 32'h0, 3'b101, 32'h00001122, 1'b0};
        tbl[6]  = '{1'b0, 9'h023, 32'h0, 3'b000, 32'h00000011, 1'b0};
        tbl[7]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0};
        tbl[9]  = '{1'b1, 9'h012, 32'h0000CAFE, 3'b001, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 9'h010, 32'h0, 3'b010, 32'hCAFEBEEF, 1'b0};
        tbl[11] = '{1'b0, 9'h012, 32'h0, 3'b001, 32'hFFFFCAFE, 1'b0};
        tbl[12] = '{1'b0, 9'h010, 32'h0, 3'b100, 32'h000000EF, 1'b0};
        tbl[13] = '{1'b0, 9'h010, 32'h0, 3'b011, 32'hCAFEBEEF, 1'b0};
        tbl[14] = '{1'b0, 9'h010, 32'h0, 3'b110, 32'hCAFEBEEF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl[15] = '{1'b0, 9'h013, 32'h0, 3'b010, 32'h0, 1'b1};
        tbl[16] = '{1'b0, 9'h011, 32'h0, 3'b001, 32'h0, 1'b1};
        tbl[17] = '{1'b1, 9'h013, 32'h55555555, 3'b010, 32'h0, 1'b1};
        tbl[18] = '{1'b0, 9'h010, 32'h0, 3'b010, 32'hCAFEBEEF, 1'b0};
`else
        tbl[15] = '{1'b0, 9'h013, 32'h0, 3'b010, 32'hCAFEBEEF, 1'b0};
        tbl[16] = '{1'b0, 9'h011, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0};
        tbl[17] = '{1'b1, 9'h013, 32'h55555555, 3'b010, 32'h0, 1'b0};
        tbl[18] = '{1'b0, 9'h010, 32'h0, 3'b010, 32'h55555555, 1'b0};
`endif
        tbl[19] = '{1'b1, 9'h000, 32'h01020304, 3'b010, 32'h0, 1'b0};
        tbl[20] = '{1'b1, 9'h1FC, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0};
        tbl[21] = '{1'b0, 9'h1FC, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0};
        tbl[22] = '{1'b0, 9'h000, 32'h0, 3'b010, 32'h01020304, 1'b0};
        tbl[23] = '{1'b1, 9'h022, 32'h00000012, 3'b000, 32'h0, 1'b0};
        tbl[24] = '{1'b0, 9'h020, 32'h0, 3'b010, 32'h11128044, 1'b0};
        tbl[25] = '{1'b1, 9'h040, 32'h77777777, 3'b010, 32'h0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        reset = 0;

        for (int i = 0; i < 26; i++) send(tbl[i]);

        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 9'h040; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'h1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        chk("abort_resp", 32'(resp_valid), 32'h0);
        repeat (3) @(negedge clk);

        reset = 1; req_valid = 1; req_wdata = 32'h99999999;
        @(negedge clk);
        reset = 0; req_valid = 0;
        chk("rst_no_accept", 32'(busy), 32'h0);
        send('{1'b0, 9'h040, 32'h0, 3'b010, 32'h77777777, 1'b0});

        @(negedge clk);
        req_valid_z = 1; req_we_z = 1; req_addr_z = 9'h004; req_wdata_z = 32'h600DF00D; req_funct3_z = 3'b010;
        @(posedge clk);
        #1 req_valid_z = 0;
        repeat (2) @(negedge clk);
        req_valid_z = 1; req_we_z = 0;
        nacc = 0; nresp = 0; c0 = 0; stop = 0;
        for (int s = 0; s < 12; s++) begin
            if (s > 0) @(negedge clk);
            if (resp_valid_z) begin
                chk("z_timing", 32'(cyc - c0), 32'(1 + 2 * nresp));
                chk("z_rdata", resp_rdata_z, 32'h600DF00D);
                nresp++;
            end
            if (stop) req_valid_z = 0;
            if (req_valid_z && req_ready_z) begin
                if (nacc == 0) c0 = cyc;
                nacc++;
                if (nacc == 3) stop = 1;
            end
        end
        chk("z_accepts", 32'(nacc), 32'd3);
        chk("z_resps", 32'(nresp), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width; storage depth 2**(DM_ADDRESS-2) 32-bit words.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..7, extra access cycles before response.
REQ-004 clk  input  1  clock; reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  DM_ADDRESS  byte address.
REQ-010 req_wdata  input  DATA_W  store data, right-aligned.
REQ-011 req_funct3  input  3  RISC-V access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  DATA_W  extended load data; 0 on stores.
REQ-014 resp_err  output  1  misaligned access flag, valid with resp_valid.
REQ-015 busy  output  1  high whenever state is not IDLE; drives the pipeline stall.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 Transitions: IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES=0; WAIT->RESP when the wait counter reaches WAIT_CYCLES-1; RESP->IDLE unconditionally.
REQ-018 req_ready = 1 only in IDLE; accept = req_valid && req_ready; request fields are latched on accept.
REQ-019 In IDLE with req_valid=0, the state is unchanged and the request inputs are ignored.
REQ-020 resp_valid is high for exactly one cycle, in RESP.
REQ-021 Latency from the accept edge to resp_valid is WAIT_CYCLES+1 cycles.
REQ-022 Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-023 Stores commit to storage on the clock edge that enters RESP, with byte enables: sb addr[1:0] lane, sh addr[1] half, sw all four.
REQ-024 Loads read the addressed word and select the byte/half lane by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passes through.
REQ-025 funct3 values 011, 110 and 111 are treated as word accesses.
REQ-026 resp_rdata and resp_err are held at 0 outside RESP.
REQ-027 A store followed by a load of the same address returns the stored data; there is no read-after-write hazard window.
REQ-028 Address wrap: req_addr bits above DM_ADDRESS-1 do not exist; the top word is index 2**(DM_ADDRESS-2)-1, and no address aliasing occurs beyond that.

Reset
REQ-029 Reset forces state IDLE, wait counter 0, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Reset in WAIT abandons the request; a pending store is not committed.
REQ-031 Reset does not clear storage contents.
REQ-032 Reset asserted in the same cycle as req_valid results in no accept.

Configuration
REQ-033 Macro DMEM_MISALIGN_TRAP_EN, defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, raises resp_err=1 in RESP, performs no storage write, and returns resp_rdata=0.
REQ-034 Macro DMEM_MISALIGN_TRAP_EN, undefined: the offending low address bits are forced to 0 (aligned access) and resp_err is tied to 0.

Structure
REQ-035 Shared package Dmem_Resp_PKG holds the FSM state enum, the funct3 localparams (F3_LB..F3_LHU), and a packed request struct {we, addr, wdata, funct3}.
REQ-036 Sub-module load_extract is combinational: it takes the word, addr[1:0] and funct3, and outputs the extended load data.
REQ-037 Storage is a word array inside dmem_responder; there is no external memory port.

Verification
REQ-038 WAIT_CYCLES=1: sw 0xDEADBEEF @0x010, then lw @0x010 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, req_ready low 2 cycles per access.
REQ-039 Load extension: sb 0x80 @0x021, then lb @0x021 -> 0xFFFFFF80; lbu @0x021 -> 0x00000080; lh @0x020 -> 0xFFFF80xx, where xx is the prior byte at 0x020.
REQ-040 Misaligned with the macro defined: lw @0x013 -> resp_err=1, rdata 0; sw @0x013 leaves word 0x010 unchanged. With the macro undefined, the same lw returns word 0x010 and err=0.
REQ-041 Reset pulse while in WAIT on sw 0x12345678 @0x040 -> no resp_valid, state IDLE next cycle, later lw @0x040 returns the old value.
REQ-042 WAIT_CYCLES=0: continuous req_valid with 3 loads -> resp_valid on cycles 1, 3, 5 after the first accept, exactly one accept per response.
REQ-043 Top address: sw 0xA5A5A5A5 @0x1FC, then lw @0x1FC -> 0xA5A5A5A5, and word 0x000 is unchanged.
